onehot_decoder_pipe: RTL and testbench

Parametrised, pipelined binary-to-one-hot decoder with valid/ready handshake on both sides. It is the successor to the combinational 5-to-32 register-select decoder. It generates register-file write-select vectors in the datapath and adds:
- an enable input
- out-of-range detection
- a saturating error counter
- a two-entry skid buffer, so that in_ready is driven from a flop

---
 rtl/dec_pkg.sv | 15 +
 rtl/onehot_dec_comb.sv | 32 +++
 rtl/onehot_decoder_pipe.sv | 120 ++++++++++++
 tb/tb_onehot_decoder_pipe.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared constants and the result-entry layout for the one-hot decoder family.
package dec_pkg;

    localparam int DEC_IN_W  = 5;
    localparam int DEC_OUT_W = 32;
    localparam int DEC_CNT_W = 8;

    // Entry layout at the default width; parameterised users declare the same
    // layout locally at their own OUT_W.
    typedef struct packed {
        logic [DEC_OUT_W-1:0] onehot;
        logic                 err;
    } dec_entry_t;

endpackage

// File: rtl/onehot_dec_comb.sv
// Combinational binary-to-one-hot map with out-of-range flag.
// DEC_ZERO_MASK_EN: code 0 never selects (hardwired zero register).
module onehot_dec_comb
    import dec_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = DEC_OUT_W
) (
    input  logic [IN_W-1:0]  code,
    input  logic             en,
    output logic [OUT_W-1:0] onehot,
    output logic             err
);

    // One extra bit so OUT_W == 2**IN_W is representable as the limit.
    localparam logic [IN_W:0] LIMIT = (IN_W+1)'(OUT_W);

    always_comb begin
        err    = ({1'b0, code} >= LIMIT);
        onehot = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (en && !err && ({1'b0, code} == (IN_W+1)'(i))) begin
                onehot[i] = 1'b1;
            end
        end
`ifdef DEC_ZERO_MASK_EN
        onehot[0] = 1'b0;
`else
`endif
    end

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Pipelined one-hot decoder with valid/ready, two-entry skid buffer and
// saturating out-of-range counter. DEC_ZERO_MASK_EN masks code 0 in the decoder.
module onehot_decoder_pipe
    import dec_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int OUT_W = DEC_OUT_W,
    parameter int CNT_W = DEC_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             clr_err
);

    typedef struct packed {
        logic [OUT_W-1:0] onehot;
        logic             err;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [OUT_W-1:0] dec_onehot;
    logic             dec_err;
    entry_t           new_entry;
    entry_t           out_d, out_q;
    entry_t           skid_d, skid_q;
    logic             out_vld_d, out_vld_q;
    logic             skid_vld_d, skid_vld_q;
    logic             in_rdy_d, in_rdy_q;
    logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic             accept;

    onehot_dec_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_dec (
        .code   (in_code),
        .en     (in_en),
        .onehot (dec_onehot),
        .err    (dec_err)
    );

    always_comb begin
        new_entry.onehot = dec_onehot;
        new_entry.err    = dec_err;
        accept           = in_valid && in_rdy_q;

        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        // Drain: the skid entry (if any) refills the output register.
        if (out_vld_q && out_ready) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d  = 1'b0;
            end
        end

        // in_rdy_q low whenever skid is occupied, so accept never collides with the skid drain.
        if (accept) begin
            if (!out_vld_q || out_ready) begin
                out_d     = new_entry;
                out_vld_d = 1'b1;
            end else begin
                skid_d     = new_entry;
                skid_vld_d = 1'b1;
            end
        end

        in_rdy_d = !skid_vld_d;

        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = (accept && new_entry.err) ? CNT_W'(1) : '0;
        end else if (accept && new_entry.err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            in_rdy_q   <= 1'b1;
            err_cnt_q  <= '0;
        end else begin
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            in_rdy_q   <= in_rdy_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Skid payload is qualified by skid_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign in_ready   = in_rdy_q;
    assign out_valid  = out_vld_q;
    assign out_onehot = out_q.onehot;
    assign out_err    = out_q.err;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: default instance (32 outputs, 8-bit counter)
// and a narrow instance (20 outputs, 2-bit counter) against a queue model.
`timescale 1ns/1ps
module tb_onehot_decoder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic        a_in_valid, a_in_ready, a_in_en, a_out_valid, a_out_ready, a_out_err, a_clr_err;
    logic [4:0]  a_in_code;
    logic [31:0] a_out_onehot;
    logic [7:0]  a_err_cnt;

    logic        b_in_valid, b_in_ready, b_in_en, b_out_valid, b_out_ready, b_out_err, b_clr_err;
    logic [4:0]  b_in_code;
    logic [19:0] b_out_onehot;
    logic [1:0]  b_err_cnt;

    int errors = 0;
    int checks = 0;

    logic [32:0] a_q[$];
    logic [32:0] b_q[$];
    int a_cnt = 0;
    int b_cnt = 0;

    onehot_decoder_pipe #(.IN_W(5), .OUT_W(32), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_code(a_in_code), .in_en(a_in_en), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_onehot(a_out_onehot), .out_err(a_out_err), .err_cnt(a_err_cnt), .clr_err(a_clr_err)
    );

    onehot_decoder_pipe #(.IN_W(5), .OUT_W(20), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_code(b_in_code), .in_en(b_in_en), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_onehot(b_out_onehot), .out_err(b_out_err), .err_cnt(b_err_cnt), .clr_err(b_clr_err)
    );

    // Reference decode: {err, onehot} zero-extended to 32 result bits.
    function automatic logic [32:0] ref_dec(input int code, input bit en, input int out_w);
        logic [32:0] r;
        r = '0;
        if (code >= out_w) r[32] = 1'b1;
        else if (en) r[31:0] = 32'd1 << code;
`ifdef DEC_ZERO_MASK_EN
        if (code == 0) r[31:0] = '0;
`endif
        return r;
    endfunction

    // Model bookkeeping just after each falling edge: the transfers seen now
    // take effect at the coming rising edge.
    always @(negedge clk) begin
        logic [32:0] ra, rb;
        #1;
        if (!rst_n) begin
            a_q.delete(); b_q.delete();
            a_cnt = 0; b_cnt = 0;
        end else begin
            ra = ref_dec(int'(a_in_code), a_in_en, 32);
            rb = ref_dec(int'(b_in_code), b_in_en, 20);
            if (a_out_valid && a_out_ready && a_q.size() > 0) void'(a_q.pop_front());
            if (b_out_valid && b_out_ready && b_q.size() > 0) void'(b_q.pop_front());
            if (a_clr_err) a_cnt = (a_in_valid && a_in_ready && ra[32]) ? 1 : 0;
            else if (a_in_valid && a_in_ready && ra[32] && a_cnt < 255) a_cnt++;
            if (b_clr_err) b_cnt = (b_in_valid && b_in_ready && rb[32]) ? 1 : 0;
            else if (b_in_valid && b_in_ready && rb[32] && b_cnt < 3) b_cnt++;
            if (a_in_valid && a_in_ready) a_q.push_back(ra);
            if (b_in_valid && b_in_ready) b_q.push_back(rb);
        end
    end

    task automatic test_reset();
        {a_in_valid, a_in_en, a_out_ready, a_clr_err, a_in_code} = '0;
        {b_in_valid, b_in_en, b_out_ready, b_clr_err, b_in_code} = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_onehot !== '0 || a_out_err !== 1'b0 || a_err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_a: valid=%b rdy=%b onehot=%h err=%b cnt=%0d, want 0 1 0 0 0",
                     a_out_valid, a_in_ready, a_out_onehot, a_out_err, a_err_cnt);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_onehot !== '0 || b_out_err !== 1'b0 || b_err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_b: valid=%b rdy=%b onehot=%h err=%b cnt=%0d, want 0 1 0 0 0",
                     b_out_valid, b_in_ready, b_out_onehot, b_out_err, b_err_cnt);
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: valid=%b rdy=%b, want 0 1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_sweep();
        logic [32:0] exp_v;
        a_out_ready = 1'b1;
        for (int c = 0; c <= 32; c++) begin
            @(posedge clk); #1;
            a_in_valid = (c < 32);
            a_in_code  = 5'(c);
            a_in_en    = 1'b1;
            @(negedge clk);
            if (c < 32) begin
                checks++;
                if (a_in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep_ready code=%0d: in_ready=%b, want 1", c, a_in_ready);
                end
            end
            if (c > 0) begin
                exp_v = ref_dec(c - 1, 1'b1, 32);
                checks++;
                if (a_out_valid !== 1'b1 || {a_out_err, a_out_onehot} !== exp_v) begin
                    errors++;
                    $display("FAIL sweep_out code=%0d: valid=%b got=%h, want 1 %h",
                             c - 1, a_out_valid, {a_out_err, a_out_onehot}, exp_v);
                end
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_disable();
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_code = 5'd7; a_in_en = 1'b0; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_en = 1'b1;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_onehot !== 32'h0 || a_out_err !== 1'b0 || int'(a_err_cnt) !== a_cnt) begin
            errors++;
            $display("FAIL disable: valid=%b onehot=%h err=%b cnt=%0d, want 1 00000000 0 %0d",
                     a_out_valid, a_out_onehot, a_out_err, a_err_cnt, a_cnt);
        end
    endtask

    task automatic test_range();
        int          codes[3];
        logic [32:0] want[3];
        logic [32:0] got;
        codes = '{19, 20, 31};
        want  = '{{1'b0, 32'h0008_0000}, {1'b1, 32'h0}, {1'b1, 32'h0}};
        b_out_ready = 1'b1; b_in_en = 1'b1; b_clr_err = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            @(posedge clk); #1;
            b_in_valid = (i < 3);
            if (i < 3) b_in_code = 5'(codes[i]);
            @(negedge clk);
            if (i > 0) begin
                got = {b_out_err, 12'h0, b_out_onehot};
                checks++;
                if (b_out_valid !== 1'b1 || got !== want[i-1]) begin
                    errors++;
                    $display("FAIL range_out code=%0d: valid=%b got=%h, want 1 %h",
                             codes[i-1], b_out_valid, got, want[i-1]);
                end
            end
        end
        checks++;
        if (b_err_cnt !== 2'd2) begin
            errors++;
            $display("FAIL range_cnt: err_cnt=%0d, want 2", b_err_cnt);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_code = 5'd25; b_clr_err = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_clr_err = 1'b0;
        @(negedge clk);
        checks++;
        if (b_err_cnt !== 2'd1 || b_out_err !== 1'b1 || b_out_onehot !== '0) begin
            errors++;
            $display("FAIL clr_with_oor: cnt=%0d err=%b onehot=%h, want 1 1 00000", b_err_cnt, b_out_err, b_out_onehot);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] got[3];
        int          n = 0;
        bit          sent = 1'b0;
        a_out_ready = 1'b0; a_in_en = 1'b1;
        @(posedge clk); #1; a_in_valid = 1'b1; a_in_code = 5'd3;
        @(posedge clk); #1; a_in_code = 5'd4;
        @(posedge clk); #1; a_in_code = 5'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_onehot !== 32'h8) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d: rdy=%b valid=%b onehot=%h, want 0 1 00000008",
                         k, a_in_ready, a_out_valid, a_out_onehot);
            end
            @(posedge clk);
        end
        for (int k = 0; k < 10 && n < 3; k++) begin
            #1;
            a_out_ready = 1'b1;
            if (sent) a_in_valid = 1'b0;
            @(negedge clk);
            if (a_in_valid && a_in_ready) sent = 1'b1;
            if (a_out_valid && a_out_ready) begin
                got[n] = a_out_onehot;
                n++;
            end
            @(posedge clk);
        end
        #1 a_in_valid = 1'b0;
        checks++;
        if (n !== 3 || got[0] !== 32'h8 || got[1] !== 32'h10 || got[2] !== 32'h20) begin
            errors++;
            $display("FAIL bp_drain: count=%0d seq=%h %h %h, want 3 00000008 00000010 00000020",
                     n, got[0], got[1], got[2]);
        end
    endtask

    task automatic test_saturation();
        int want[4];
        want = '{1, 2, 3, 3};
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        b_out_ready = 1'b1; b_in_en = 1'b1; b_clr_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            b_in_valid = 1'b1; b_in_code = 5'($urandom_range(31, 20));
            @(posedge clk); #1;
            b_in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (int'(b_err_cnt) !== want[i]) begin
                errors++;
                $display("FAIL saturate step=%0d: err_cnt=%0d, want %0d", i, b_err_cnt, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] exp_v;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        a_in_en = 1'b1; b_in_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1; a_in_code = 5'($urandom_range(31, 0));
            b_in_valid = 1'b1; b_in_code = 5'($urandom_range(31, 20));
        end
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || int'(b_err_cnt) !== b_cnt || b_err_cnt === 2'd0) begin
            errors++;
            $display("FAIL fill_before_reset: rdy_a=%b rdy_b=%b cnt_b=%0d, want 0 0 %0d",
                     a_in_ready, b_in_ready, b_err_cnt, b_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_onehot !== '0 ||
            b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_err_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: va=%b ra=%b oa=%h vb=%b rb=%b cb=%0d, want 0 1 0 0 1 0",
                     a_out_valid, a_in_ready, a_out_onehot, b_out_valid, b_in_ready, b_err_cnt);
        end
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b1; a_in_code = 5'd1; a_out_ready = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_code = 5'd0;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_onehot !== 32'h2 || a_out_err !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_code1: valid=%b onehot=%h err=%b, want 1 00000002 0",
                     a_out_valid, a_out_onehot, a_out_err);
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        exp_v = ref_dec(0, 1'b1, 32);
        checks++;
        if (a_out_valid !== 1'b1 || {a_out_err, a_out_onehot} !== exp_v) begin
            errors++;
            $display("FAIL after_reset_code0: valid=%b got=%h, want 1 %h", a_out_valid, {a_out_err, a_out_onehot}, exp_v);
        end
    endtask

    task automatic test_random();
        logic [32:0] got_b;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            a_in_valid  = ($urandom_range(3, 0) != 0);
            a_in_code   = 5'($urandom_range(31, 0));
            a_in_en     = ($urandom_range(3, 0) != 0);
            a_out_ready = ($urandom_range(2, 0) != 0);
            a_clr_err   = ($urandom_range(15, 0) == 0);
            b_in_valid  = ($urandom_range(3, 0) != 0);
            b_in_code   = 5'($urandom_range(31, 0));
            b_in_en     = ($urandom_range(3, 0) != 0);
            b_out_ready = ($urandom_range(2, 0) != 0);
            b_clr_err   = ($urandom_range(15, 0) == 0);
            @(negedge clk);
            checks++;
            if (a_out_valid !== (a_q.size() > 0) || a_in_ready !== (a_q.size() < 2) || int'(a_err_cnt) !== a_cnt ||
                (a_q.size() > 0 && {a_out_err, a_out_onehot} !== a_q[0])) begin
                errors++;
                $display("FAIL rand_a cycle=%0d: valid=%b rdy=%b cnt=%0d data=%h, want %b %b %0d %h",
                         k, a_out_valid, a_in_ready, a_err_cnt, {a_out_err, a_out_onehot},
                         a_q.size() > 0, a_q.size() < 2, a_cnt, (a_q.size() > 0) ? a_q[0] : 33'h0);
            end
            got_b = {b_out_err, 12'h0, b_out_onehot};
            checks++;
            if (b_out_valid !== (b_q.size() > 0) || b_in_ready !== (b_q.size() < 2) || int'(b_err_cnt) !== b_cnt ||
                (b_q.size() > 0 && got_b !== b_q[0])) begin
                errors++;
                $display("FAIL rand_b cycle=%0d: valid=%b rdy=%b cnt=%0d data=%h, want %b %b %0d %h",
                         k, b_out_valid, b_in_ready, b_err_cnt, got_b,
                         b_q.size() > 0, b_q.size() < 2, b_cnt, (b_q.size() > 0) ? b_q[0] : 33'h0);
            end
        end
        @(posedge clk); #1;
        {a_in_valid, a_clr_err, b_in_valid, b_clr_err} = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sweep();
        test_disable();
        test_range();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
